// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops the CP_LEN-sample prefix of each OFDM symbol and forwards FFT_LEN payload samples.
// Optional build macro CP_REMOVER_ZERO_PAD_EN zero-pads a truncated final symbol instead of aborting it.
module cp_remover #(
  parameter int DATA_W  = 12,
  parameter int CP_LEN  = 16,
  parameter int FFT_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in_re,
  input  logic [DATA_W-1:0] data_in_im,
  input  logic              last_symbol_in,
  output logic [DATA_W-1:0] data_out_re,
  output logic [DATA_W-1:0] data_out_im,
  output logic              valid_out,
  output logic              sym_start,
  output logic              sym_end,
  output logic              frame_done,
  output logic              sym_abort,
  output logic [7:0]        sym_count
);

  localparam int SYM_LEN = CP_LEN + FFT_LEN;
  localparam int IDX_W   = $clog2(SYM_LEN);

  localparam logic [IDX_W-1:0] IDX_ZERO      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST_CP   = IDX_W'(CP_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST_PAY = IDX_W'(CP_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(SYM_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SKIP = 3'd1,
    ST_PASS = 3'd2,
    ST_DONE = 3'd3
`ifdef CP_REMOVER_ZERO_PAD_EN
    , ST_PAD = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic [IDX_W-1:0]  idx_post;
  logic [7:0]        sym_count_q, sym_count_d;
  logic [DATA_W-1:0] data_re_q, data_re_d;
  logic [DATA_W-1:0] data_im_q, data_im_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Next-state, index and output decode for the symbol framing FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idx_post    = idx_q;
    sym_count_d = sym_count_q;
    data_re_d   = '0;
    data_im_d   = '0;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    end_d       = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    if (idx_q == IDX_LAST) begin
      idx_inc = IDX_ZERO;
    end else begin
      idx_inc = idx_q + IDX_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (valid_in && !last_symbol_in) begin
          idx_d       = IDX_W'(1);
          sym_count_d = 8'd0;
          state_d     = ST_SKIP;
        end else begin
          idx_d = IDX_ZERO;
        end
      end

      ST_SKIP: begin
        if (valid_in) begin
          idx_d = idx_inc;
          if (idx_q == IDX_LAST_CP) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_SKIP;
          end
        end else begin
          idx_d = idx_q;
        end
        // Ending inside the prefix never loses payload, so no abort is reported.
        if (last_symbol_in) begin
          state_d = ST_DONE;
          idx_d   = IDX_ZERO;
          done_d  = 1'b1;
        end else begin
          done_d  = 1'b0;
        end
      end

      ST_PASS: begin
        if (valid_in) begin
          valid_d   = 1'b1;
          data_re_d = data_in_re;
          data_im_d = data_in_im;
          start_d   = (idx_q == IDX_FIRST_PAY);
          idx_post  = idx_inc;
          if (idx_q == IDX_LAST) begin
            end_d       = 1'b1;
            sym_count_d = sat_inc(sym_count_q);
            state_d     = ST_SKIP;
          end else begin
            state_d     = ST_PASS;
          end
        end else begin
          idx_post = idx_q;
        end
        idx_d = idx_post;
        // Termination is judged on the index after this cycle's sample is taken.
        if (last_symbol_in) begin
          if ((idx_post == IDX_ZERO) || (idx_post == IDX_FIRST_PAY)) begin
            state_d = ST_DONE;
            idx_d   = IDX_ZERO;
            done_d  = 1'b1;
          end else begin
`ifdef CP_REMOVER_ZERO_PAD_EN
            state_d = ST_PAD;
`else
            state_d = ST_DONE;
            idx_d   = IDX_ZERO;
            done_d  = 1'b1;
            abort_d = 1'b1;
`endif
          end
        end else begin
          done_d = 1'b0;
        end
      end

`ifdef CP_REMOVER_ZERO_PAD_EN
      ST_PAD: begin
        valid_d = 1'b1;
        idx_d   = idx_inc;
        if (idx_q == IDX_LAST) begin
          end_d       = 1'b1;
          sym_count_d = sat_inc(sym_count_q);
          state_d     = ST_DONE;
          done_d      = 1'b1;
        end else begin
          state_d     = ST_PAD;
        end
      end
`endif

      ST_DONE: begin
        idx_d = IDX_ZERO;
        if (!last_symbol_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      sym_count_q <= 8'd0;
      data_re_q   <= '0;
      data_im_q   <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sym_count_q <= sym_count_d;
      data_re_q   <= data_re_d;
      data_im_q   <= data_im_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      end_q       <= end_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign data_out_re = data_re_q;
  assign data_out_im = data_im_q;
  assign valid_out   = valid_q;
  assign sym_start   = start_q;
  assign sym_end     = end_q;
  assign frame_done  = done_q;
  assign sym_abort   = abort_q;
  assign sym_count   = sym_count_q;

endmodule

// File: tb/tb_cp_remover.sv
// Self-checking bench for cp_remover: scenario table plus output scoreboard and a mid-frame reset sequence.
module tb_cp_remover;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] data_in_re, data_in_im;
  logic          last_symbol_in;
  logic [DW-1:0] data_out_re, data_out_im;
  logic          valid_out, sym_start, sym_end, frame_done, sym_abort;
  logic [7:0]    sym_count;

  int tests = 0;
  int fails = 0;
  int n_out = 0;
  int n_done = 0;
  int n_abort = 0;
  bit prev_done = 1'b0;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          s;
    logic          e;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int n;
    bit gap;
    int exp_outs;
    int exp_cnt;
    int exp_abort;
  } vec_t;

  always #5 clk = ~clk;

  cp_remover #(.DATA_W(DW), .CP_LEN(16), .FFT_LEN(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .data_in_re(data_in_re), .data_in_im(data_in_im),
    .last_symbol_in(last_symbol_in),
    .data_out_re(data_out_re), .data_out_im(data_out_im),
    .valid_out(valid_out), .sym_start(sym_start), .sym_end(sym_end),
    .frame_done(frame_done), .sym_abort(sym_abort), .sym_count(sym_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid output and checks pulse rules.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) begin
      n_done++;
      check("done_single_cycle", 32'(prev_done), 32'd0);
    end
    if (sym_abort) begin
      n_abort++;
      check("abort_with_done", 32'(frame_done), 32'd1);
    end
    prev_done = frame_done;
    if (sym_start || sym_end) check("flag_needs_valid", 32'(valid_out), 32'd1);
    if (valid_out) begin
      n_out++;
      if (q.size() == 0) begin
        check("output_expected", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        check("out_word", {6'd0, data_out_re, data_out_im, sym_start, sym_end},
              {6'd0, e.re, e.im, e.s, e.e});
      end
    end
  end

  task automatic drive_sample(input int k);
    exp_t e;
    valid_in   = 1'b1;
    data_in_re = DW'(k);
    data_in_im = DW'(k) ^ 12'hABC;
    if ((k % 80) >= 16) begin
      e.re = DW'(k);
      e.im = DW'(k) ^ 12'hABC;
      e.s  = ((k % 80) == 16);
      e.e  = ((k % 80) == 79);
      q.push_back(e);
    end
  endtask

  task automatic run_frame(input int n, input bit gap);
    int k;
    bit ph;
    k  = 0;
    ph = 1'b0;
    while (k < n) begin
      @(posedge clk); #1;
      if (gap && ph) begin
        valid_in   = 1'b0;
        data_in_re = 12'hFFF;
        data_in_im = 12'hFFF;
      end else begin
        drive_sample(k);
        k++;
      end
      ph = ~ph;
    end
    @(posedge clk); #1;
    valid_in       = 1'b0;
    last_symbol_in = 1'b1;
`ifdef CP_REMOVER_ZERO_PAD_EN
    if ((n % 80) > 16) begin
      for (int j = n % 80; j < 80; j++) begin
        exp_t z;
        z.re = '0;
        z.im = '0;
        z.s  = 1'b0;
        z.e  = (j == 79);
        q.push_back(z);
      end
    end
`endif
    repeat (70) @(posedge clk);
    #1 last_symbol_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t vt[6];
`ifdef CP_REMOVER_ZERO_PAD_EN
    vt[0] = '{160, 1'b0, 128, 2, 0};
    vt[1] = '{160, 1'b1, 128, 2, 0};
    vt[2] = '{100, 1'b0, 128, 2, 0};
    vt[3] = '{90,  1'b0, 64,  1, 0};
    vt[4] = '{96,  1'b0, 64,  1, 0};
    vt[5] = '{97,  1'b0, 128, 2, 0};
`else
    vt[0] = '{160, 1'b0, 128, 2, 0};
    vt[1] = '{160, 1'b1, 128, 2, 0};
    vt[2] = '{100, 1'b0, 68,  1, 1};
    vt[3] = '{90,  1'b0, 64,  1, 0};
    vt[4] = '{96,  1'b0, 64,  1, 0};
    vt[5] = '{97,  1'b0, 65,  1, 1};
`endif

    reset          = 1'b1;
    valid_in       = 1'b0;
    last_symbol_in = 1'b0;
    data_in_re     = '0;
    data_in_im     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data", {8'd0, data_out_re, data_out_im}, 32'd0);
    check("rst_flags", {28'd0, sym_start, sym_end, frame_done, sym_abort}, 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      n_out   = 0;
      n_done  = 0;
      n_abort = 0;
      run_frame(vt[i].n, vt[i].gap);
      check($sformatf("s%0d_n_out", i), 32'(n_out), 32'(vt[i].exp_outs));
      check($sformatf("s%0d_sym_count", i), 32'(sym_count), 32'(vt[i].exp_cnt));
      check($sformatf("s%0d_frame_done", i), 32'(n_done), 32'd1);
      check($sformatf("s%0d_sym_abort", i), 32'(n_abort), 32'(vt[i].exp_abort));
      check($sformatf("s%0d_queue_empty", i), 32'(q.size()), 32'd0);
    end

    // Reset while the frame is at sample index 40.
    n_out  = 0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      drive_sample(k);
    end
    @(posedge clk); #1;
    valid_in   = 1'b1;
    data_in_re = DW'(40);
    data_in_im = DW'(40) ^ 12'hABC;
    reset      = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_out", 32'(valid_out), 32'd0);
    check("mid_rst_data", {8'd0, data_out_re, data_out_im}, 32'd0);
    check("mid_rst_flags", {28'd0, sym_start, sym_end, frame_done, sym_abort}, 32'd0);
    check("mid_rst_n_out", 32'(n_out), 32'd24);
    check("mid_rst_no_done", 32'(n_done), 32'd0);
    check("mid_rst_queue_empty", 32'(q.size()), 32'd0);

    n_out   = 0;
    n_done  = 0;
    n_abort = 0;
    run_frame(80, 1'b0);
    check("post_rst_n_out", 32'(n_out), 32'd64);
    check("post_rst_sym_count", 32'(sym_count), 32'd1);
    check("post_rst_frame_done", 32'(n_done), 32'd1);
    check("post_rst_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
